// File: rtl/my_pkg.sv
// -----------------------------------------------------------------------------
// my_pkg
// Shared definitions for the aggregation engine's grant-side service engine:
//   - N_REQ_DFLT   : default number of requesters (matches arbiter width)
//   - IDX_W/VEC_W  : index width and the widest one-hot vector the helpers take
//   - srv_state_t  : service FSM state encoding
//   - is_onehot    : exactly-one-bit-set test (also used by the arbiter metric)
//   - onehot_to_idx: one-hot to binary index encoder
// -----------------------------------------------------------------------------
package my_pkg;

  localparam int N_REQ_DFLT = 5;
  localparam int IDX_W      = 3;
  localparam int VEC_W      = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } srv_state_t;

  // Callers zero-extend narrower vectors to VEC_W bits.
  function automatic logic is_onehot(input logic [VEC_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
  endfunction

  // Result is only meaningful when is_onehot(v) holds.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [VEC_W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < VEC_W; i++) begin
      if (v[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/srv_timeout_cnt.sv
// -----------------------------------------------------------------------------
// srv_timeout_cnt
// Read-return watchdog counter for agg_grant_server.
//   clk, arst_n : clock, asynchronous active-low reset
//   clr_i       : synchronous clear (has priority over en_i)
//   en_i        : increment by one this cycle
//   expire_o    : count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module srv_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // The owner leaves the counting state on expiry, so no saturation is needed.
  assign expire_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/agg_grant_server.sv
// -----------------------------------------------------------------------------
// agg_grant_server
// Grant-side service engine behind the 5-way round-robin arbiter. Samples the
// one-hot grant in IDLE, latches the winner's access, performs it on the shared
// port (req/gnt, then rvalid for reads), and returns the response to the winner
// while pulsing req_satisfied. One access in flight at a time.
//
// Ports:
//   clk, arst_n        : clock, asynchronous active-low reset
//   grant              : one-hot grant from arbiter (only sampled in IDLE)
//   req_we/addr/wdata  : packed per-requester access fields, slice i = req i
//   req_satisfied      : one-cycle completion pulse to the arbiter
//   rsp_valid          : one-hot response strobe to the served requester
//   rsp_data, rsp_err  : read data (0 for writes/aborts), timeout abort flag
//   mem_req/we/addr/wdata : shared-port request with latched fields
//   mem_gnt            : shared port accepts the request
//   mem_rvalid/rdata   : shared-port read return
//   busy               : FSM not in IDLE
//   proto_err          : sticky, multi-hot grant observed in IDLE
//
// All outputs decode registered state/fields only.
// -----------------------------------------------------------------------------
module agg_grant_server
  import my_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DFLT,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [N_REQ-1:0]         grant,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic                     req_satisfied,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy,
  output logic                     proto_err
);

  srv_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              abort_q, abort_d;
  logic              proto_err_q, proto_err_d;

  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_expire;

  logic [VEC_W-1:0]  grant_ext;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_onehot;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign grant_ext    = VEC_W'(grant);
  assign grant_onehot = is_onehot(grant_ext);
  assign grant_idx    = onehot_to_idx(grant_ext);

  // Slice mux driven straight by the grant bits; its result is only used
  // when the grant is one-hot, so at most one iteration matches.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // The counter restarts on read acceptance and only runs while waiting.
  assign cnt_clr = (state_q == ISSUE) && mem_gnt && !we_q;
  assign cnt_en  = (state_q == WAIT);

  srv_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk      (clk),
    .arst_n   (arst_n),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .expire_o (cnt_expire)
  );

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    abort_d     = abort_q;
    proto_err_d = proto_err_q;

    unique case (state_q)
      IDLE: begin
        if (grant_onehot) begin
          idx_d   = grant_idx;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          rdata_d = '0;
          abort_d = 1'b0;
          state_d = ISSUE;
        end else if (grant != '0) begin
          // Multi-hot: flag it and latch nothing.
          proto_err_d = 1'b1;
        end
      end

      ISSUE: begin
        if (mem_gnt) state_d = we_q ? DONE : WAIT;
      end

      WAIT: begin
        // Read return wins over an expiry in the same cycle.
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = DONE;
        end else if (cnt_expire) begin
          rdata_d = '0;
          abort_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the latched access fields are reset too, so the field-driven
  // outputs (mem_we/mem_addr/mem_wdata) read 0 straight out of reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      abort_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      abort_q     <= abort_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign mem_req       = (state_q == ISSUE);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign busy          = (state_q != IDLE);
  assign proto_err     = proto_err_q;
  assign req_satisfied = (state_q == DONE);
  assign rsp_valid     = (state_q == DONE) ? (N_REQ'(1) << idx_q) : '0;
  assign rsp_data      = (state_q == DONE) ? rdata_q : '0;
  assign rsp_err       = (state_q == DONE) && abort_q;

endmodule
